uop_issue_queue: RTL
====================

Name: uop_issue_queue

Overview:
- Transmitter side of the decoder-to-reservation-station feed handshake.
- Buffers decoded micro-op bundles produced by the decoder: PC, up to three 20-bit uops, uop count, and 16-bit constant.
- Presents the oldest buffered bundle to the reservation station and completes a transfer by asserting id_feed_ack against the station's id_feed_req.
- Also absorbs decoder/station rate mismatch and discards all buffered bundles on a pipeline flush.

Parameters:
- DEPTH, 4, number of bundle entries; power of two, minimum 2.
- NOP, 20'b0000_0000_1111_00_000_000, uop encoding driven on all uop outputs when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- a_rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all buffered bundles and any push this cycle.
- dec_valid  in  1  decoder offers a bundle.
- dec_ready  out  1  queue accepts a bundle this cycle.
- dec_pc  in  16  PC of the offered bundle.
- dec_uop_0  in  20  last-executed uop.
- dec_uop_1  in  20  middle uop.
- dec_uop_2  in  20  first-executed uop when count=2.
- dec_uop_count  in  2  number of uops minus 1 (0..2); 3 is illegal.
- dec_k16  in  16  immediate/constant for the bundle.
- id_feed_req  in  1  station requests a bundle.
- id_feed_ack  out  1  head bundle is valid and transferred this cycle.
- id_pc  out  16  head PC.
- id_uop_0  out  20  head uop_0.
- id_uop_1  out  20  head uop_1.
- id_uop_2  out  20  head uop_2.
- id_uop_count  out  2  head uop count.
- id_k16  out  16  head constant.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding pc, uop_0, uop_1, uop_2, uop_count and k16 (94 bits).
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter is kept.
- Reset (a_rst high, takes effect immediately, asynchronous):
  - wr_ptr=0, rd_ptr=0, occupancy=0.
  - dec_ready=1, id_feed_ack=0.
  - id_uop_0/1/2=NOP, id_uop_count=0, id_pc=0, id_k16=0.
  - Entry contents need no reset.
- Empty/full conditions: empty = (occupancy==0); full = (occupancy==DEPTH).
- dec_ready is combinational: ~full. There is no push-on-full bypass, even when a pop occurs in the same cycle.
- push = dec_valid & dec_ready & ~flush. On push, the bundle is written at wr_ptr and wr_ptr increments.
- id_feed_ack is combinational: id_feed_req & ~empty & ~flush.
- pop = id_feed_ack. On pop, rd_ptr increments. The station samples the id_* outputs in the same cycle that ack is high.
- Head outputs are driven combinationally from the entry at rd_ptr when not empty.
  - When empty: uops=NOP, count=0, pc=0, k16=0.
- Latency: a bundle pushed in cycle N can be acked no earlier than cycle N+1. There is no same-cycle fall-through.
- Occupancy update, simultaneous push and pop:
  - push&pop: occupancy unchanged; both pointers advance.
  - push only: +1.
  - pop only: -1.
- Flush:
  - Next edge: occupancy=0 and rd_ptr=wr_ptr=0.
  - During the flush cycle, ack is forced to 0 and any push is dropped.
  - dec_ready still reflects ~full during flush.
- Ordering: strict FIFO; bundles leave in the order accepted.
- No field of a bundle is modified in the queue.
- Illegal dec_uop_count=3 is stored and forwarded unchanged; no checking is done.
- Reset asserted mid-transfer: all state clears asynchronously and ack drops immediately. Any bundle in flight is lost.

Test Plan:
- Reset then idle: a_rst=1 for 2 cycles, then release; id_feed_req=1, dec_valid=0 -> id_feed_ack=0, id_uop_0/1/2=20'h00F00, occupancy=0, dec_ready=1.
- Single bundle latency: push pc=16'h1234, uops {20'h11111, 20'h22222, 20'h33333}, count=2, k16=16'hBEEF in cycle 0, with id_feed_req=1 throughout -> ack=0 in cycle 0; ack=1 in cycle 1 with exactly those values; occupancy returns to 0 in cycle 2.
- Fill to full: DEPTH=4, push pc=1..5 on consecutive cycles with req=0 -> dec_ready=0 after the 4th push and pc=5 is not accepted; then req=1 for 4 cycles -> acks deliver pc 1,2,3,4 in order.
- Simultaneous push/pop at wrap: keep occupancy=2 while streaming pc=10..30 with push and pop every cycle -> occupancy stays 2; acks deliver pc 10..28 in order across pointer wrap.
- Flush: occupancy=3, assert flush with dec_valid=1 and req=1 -> ack=0 that cycle, pushed bundle dropped, occupancy=0 next cycle, outputs show NOP.
- Async reset mid-stream: assert a_rst between clock edges while ack=1 -> ack falls and occupancy=0 before the next edge; a post-reset push of pc=16'h00AA is delivered as the first bundle.

Source files
------------

// File: rtl/uop_issue_queue.sv
// uop_issue_queue: circular buffer of decoded micro-op bundles between the
// decoder and the reservation station. The oldest entry is presented
// combinationally and leaves when the station's request is acknowledged.
// A flush empties the queue on the next edge and drops that cycle's traffic.
module uop_issue_queue #(
    parameter int          DEPTH = 4,
    parameter logic [19:0] NOP   = 20'b0000_0000_1111_00_000_000
) (
    input  logic                       clk,
    input  logic                       a_rst,
    input  logic                       flush,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [15:0]                dec_pc,
    input  logic [19:0]                dec_uop_0,
    input  logic [19:0]                dec_uop_1,
    input  logic [19:0]                dec_uop_2,
    input  logic [1:0]                 dec_uop_count,
    input  logic [15:0]                dec_k16,
    input  logic                       id_feed_req,
    output logic                       id_feed_ack,
    output logic [15:0]                id_pc,
    output logic [19:0]                id_uop_0,
    output logic [19:0]                id_uop_1,
    output logic [19:0]                id_uop_2,
    output logic [1:0]                 id_uop_count,
    output logic [15:0]                id_k16,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [19:0] uop_0;
        logic [19:0] uop_1;
        logic [19:0] uop_2;
        logic [1:0]  uop_count;
        logic [15:0] k16;
    } bundle_t;

    bundle_t       mem_q [DEPTH];
    bundle_t       head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          empty, full, push, pop;

    assign empty       = (occ_q == '0);
    assign full        = (occ_q == OW'(DEPTH));
    // No push-on-full bypass: a pop in the same cycle does not open a slot.
    assign dec_ready   = ~full;
    assign push        = dec_valid & dec_ready & ~flush;
    assign id_feed_ack = id_feed_req & ~empty & ~flush;
    assign pop         = id_feed_ack;
    assign occupancy   = occ_q;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      occ_d = occ_q + 1'b1;
            else if (pop && !push) occ_d = occ_q - 1'b1;
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: dec_pc, uop_0: dec_uop_0, uop_1: dec_uop_1,
                                 uop_2: dec_uop_2, uop_count: dec_uop_count,
                                 k16: dec_k16};
        end
    end

    // Head view: oldest entry, or a NOP bundle when nothing is buffered.
    always_comb begin
        head = '{pc: 16'h0, uop_0: NOP, uop_1: NOP, uop_2: NOP,
                 uop_count: 2'd0, k16: 16'h0};
        if (!empty) head = mem_q[rd_ptr_q];
    end

    assign id_pc        = head.pc;
    assign id_uop_0     = head.uop_0;
    assign id_uop_1     = head.uop_1;
    assign id_uop_2     = head.uop_2;
    assign id_uop_count = head.uop_count;
    assign id_k16       = head.k16;

endmodule
